reset_seq: RTL and testbench

Parametrised reset sequencer and successor to the single-output shift-register reset stretcher. It qualifies an asynchronous clock-manager LOCKED input, then stretches reset. After that it releases NUM_CH active-low reset channels one at a time, spaced by a programmable gap, so that interconnect, core and peripherals come out of reset in order. It sits in the chip top between the clock manager and the SoC, and adds a software reset request, lock-loss recovery and status outputs.

---
 rtl/reset_seq_if.sv | 30 +++
 rtl/reset_seq.sv | 153 +++++++++++++++
 tb/tb_reset_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reset_seq_if.sv
// Control/status bundle between the reset sequencer and the chip-top logic around it.
// master drives lock and software request; slave (the sequencer) drives the channel resets and status.
interface reset_seq_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              locked;
    logic              sw_rst_req;
    logic [NUM_CH-1:0] ch_rstn;
    logic              all_released;
    logic              busy;
    logic              lock_lost;

    modport master (
        output locked,
        output sw_rst_req,
        input  ch_rstn,
        input  all_released,
        input  busy,
        input  lock_lost
    );

    modport slave (
        input  locked,
        input  sw_rst_req,
        output ch_rstn,
        output all_released,
        output busy,
        output lock_lost
    );
endinterface

// File: rtl/reset_seq.sv
// Reset sequencer: qualifies clock-manager lock, stretches reset, then releases
// NUM_CH active-low reset channels in order with a fixed gap between them.
module reset_seq #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned LOCK_FILTER    = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STAGE_GAP      = 8,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    reset_seq_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_FINAL    = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [1:0]        sync_q;
    logic              locked_s;
    logic              lock_drop;

    logic [NUM_CH-1:0] ch_q, ch_nxt;
    logic              all_rel_q, all_rel_nxt;
    logic              busy_q, busy_nxt;
    logic              lost_q, lost_nxt;

    assign locked_s  = sync_q[1];
    // Lock loss only matters once the filter has been passed.
    assign lock_drop = !locked_s && (state != HOLD);

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            state     <= HOLD;
            cnt       <= '0;
            idx       <= '0;
            ch_q      <= '0;
            all_rel_q <= 1'b0;
            busy_q    <= 1'b1;
            lost_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], bus.locked};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            ch_q      <= ch_nxt;
            all_rel_q <= all_rel_nxt;
            busy_q    <= busy_nxt;
            lost_q    <= lost_nxt;
        end
    end

    // Next state, counter and channel index
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (lock_drop || bus.sw_rst_req) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (!locked_s) begin
                        cnt_nxt = '0;
                    end else if (cnt == FILT_LAST) begin
                        state_nxt = STRETCH;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STRETCH: begin
                    if (cnt == STRETCH_LAST) begin
                        state_nxt = (NUM_CH == 1) ? RUN : RELEASE;
                        cnt_nxt   = '0;
                        idx_nxt   = IDX_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + IDX_W'(1);
                        if (idx == IDX_FINAL) begin
                            state_nxt = RUN;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        ch_nxt   = ch_q;
        lost_nxt = lost_q;
        if (lock_drop) begin
            ch_nxt   = '0;
            lost_nxt = 1'b1;
        end else if (bus.sw_rst_req) begin
            ch_nxt   = '0;
            lost_nxt = 1'b0;
        end else begin
            case (state)
                STRETCH: begin
                    if (cnt == STRETCH_LAST) begin
                        ch_nxt[0] = 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (IDX_W'(i) == idx) begin
                                ch_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        all_rel_nxt = (state_nxt == RUN);
        busy_nxt    = (state_nxt != RUN);
    end

    assign bus.ch_rstn      = ch_q;
    assign bus.all_released = all_rel_q;
    assign bus.busy         = busy_q;
    assign bus.lock_lost    = lost_q;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq: default-parameter instance plus a minimal NUM_CH=1 instance.
module tb_reset_seq;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    int   e;

    reset_seq_if #(.NUM_CH(4)) bus  ();
    reset_seq_if #(.NUM_CH(1)) bus1 ();

    reset_seq #(
        .NUM_CH(4), .LOCK_FILTER(4), .STRETCH_CYCLES(16), .STAGE_GAP(8), .CNT_W(8)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    reset_seq #(
        .NUM_CH(1), .LOCK_FILTER(1), .STRETCH_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)
    ) dut1 (
        .clk(clk), .resetn(resetn), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Status packed as {lock_lost, busy, all_released, ch_rstn}
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {bus.lock_lost, bus.busy, bus.all_released, bus.ch_rstn};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus1.lock_lost, bus1.busy, bus1.all_released, bus1.ch_rstn};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after absolute edge 'target', counted from the last reset release.
    task automatic goto(input int target);
        repeat (target - e) @(posedge clk);
        #1;
        e = target;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        e = 0;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        e               = 0;
        resetn          = 1'b0;
        bus.locked      = 1'b1;
        bus.sw_rst_req  = 1'b0;
        bus1.locked     = 1'b1;
        bus1.sw_rst_req = 1'b0;

        #12;
        chk("reset_state", 7'b0100000);
        chk1("reset_state_1ch", 4'b0100);

        // Full default sequence with lock steady
        release_reset();
        goto(3);  chk1("1ch_before", 4'b0100);
        goto(4);  chk1("1ch_release", 4'b0011);
        goto(21); chk("pre_ch0", 7'b0100000);
        goto(22); chk("ch0_rel", 7'b0100001);
        goto(29); chk("pre_ch1", 7'b0100001);
        goto(30); chk("ch1_rel", 7'b0100011);
        goto(38); chk("ch2_rel", 7'b0100111);
        goto(45); chk("pre_run", 7'b0100111);
        goto(46); chk("run", 7'b0011111);

        // Lock loss in RUN for 3 cycles
        goto(50); bus.locked = 1'b0;
        goto(52); chk("loss_pending", 7'b0011111);
        goto(53); chk("loss_hold", 7'b1100000);
        bus.locked = 1'b1;
        goto(74); chk("loss_pre_ch0", 7'b1100000);
        goto(75); chk("loss_ch0", 7'b1100001);
        goto(83); chk("loss_ch1", 7'b1100011);

        // Software request in RELEASE with idx=2
        goto(84); bus.sw_rst_req = 1'b1;
        goto(85); bus.sw_rst_req = 1'b0;
        chk("sw_hold", 7'b0100000);
        goto(104); chk("sw_pre_ch0", 7'b0100000);
        goto(105); chk("sw_ch0", 7'b0100001);

        // Lock loss and software request landing on the same edge
        bus.locked = 1'b0;
        goto(107); chk("both_pending", 7'b0100001);
        bus.sw_rst_req = 1'b1;
        goto(108); bus.sw_rst_req = 1'b0;
        chk("both_hold", 7'b1100000);
        bus.locked = 1'b1;

        // Async reset mid-STRETCH, off the clock edge
        goto(120); chk("stretch_mid", 7'b1100000);
        #2 resetn = 1'b0;
        #1 chk("async_reset", 7'b0100000);
        chk1("async_reset_1ch", 4'b0100);
        release_reset();
        goto(4);  chk1("1ch_rerelease", 4'b0011);
        goto(21); chk("re_pre_ch0", 7'b0100000);
        goto(22); chk("re_ch0", 7'b0100001);

        // One-cycle lock glitch in HOLD after 3 good filter cycles
        @(negedge clk);
        resetn = 1'b0;
        release_reset();
        goto(3); bus.locked = 1'b0;
        goto(4); bus.locked = 1'b1;
        goto(22); chk("glitch_no_ch0", 7'b0100000);
        goto(25); chk("glitch_pre_ch0", 7'b0100000);
        goto(26); chk("glitch_ch0", 7'b0100001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
